mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store access stage sitting directly upstream of the data memory. It takes one byte-addressed load or store request per cycle from the execute stage and produces the data memory's word address, per-byte write enables and lane-aligned write data. It collects the synchronous read word one cycle later and returns a sign- or zero-extended load result. Accesses that cross a word boundary are split into two memory transactions under a small FSM, stalling the requester for one cycle.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 15, word-address width of the data memory (32768 words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reqValid  in  1  request present this cycle.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqIsStore  in  1  1 = store, 0 = load.
- reqSize  in  2  MemAccessSize: 0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as a word access.
- reqUnsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- reqAddr  in  32  byte address.
- reqStoreData  in  32  store value, right-justified.
- respValid  out  1  load result valid this cycle.
- respData  out  32  extended load result.
- dmemRAddr  out  MEM_ADDR_WIDTH  memory read word address.
- dmemWAddr  out  MEM_ADDR_WIDTH  memory write word address.
- dmemWEnable  out  4  per-byte write enable; bit i covers bits [8i+7:8i].
- dmemWData  out  32  lane-aligned write data.
- dmemRData  in  32  memory read word; valid the cycle after dmemRAddr is presented.

## Operation
- Address decode:
  - word = reqAddr[MEM_ADDR_WIDTH+1:2]
  - off = reqAddr[1:0]
  - Upper address bits are ignored, so accesses wrap modulo memory size.
- Byte mask:
  - size mask (byte 0001, half 0011, word 1111) shifted left by off into 8 bits.
  - Low nibble goes to the first word; high nibble goes to word+1 (wrapping).
  - Access is split iff the high nibble ≠ 0.
- Store data: 64-bit value reqStoreData << (8*off). Low half goes to the first word, high half to the second.
- FSM states:
  - IDLE: reqReady=1. On an accepted request, drive the first-word transaction combinationally in the same cycle. If split, latch the second-word address, mask, data and load metadata, then go to SECOND; otherwise stay in IDLE.
  - SECOND: reqReady=0. Drive the second-word transaction from the latched values, then go to IDLE.
- Stores: dmemWAddr/dmemWEnable/dmemWData are driven in the transaction cycle. dmemWEnable=0 in every cycle with no store transaction.
- Loads: dmemRAddr is driven in the transaction cycle. Load metadata (off, size, unsigned, split) is registered for the return cycle.
  - Unsplit load: result is extracted from dmemRData >> (8*off) in the next cycle.
  - Split load: the first word is captured in the SECOND cycle. The result is {dmemRData, captured} >> (8*off), extracted in the cycle after SECOND.
- Extension: take the low 8/16/32 bits, then sign- or zero-extend per reqUnsigned.
- Stores never assert respValid.
- dmemRAddr is don't-care when no load is in flight; drive it to the decoded word anyway.

## Timing
- Aligned load accepted in cycle N: respValid=1 in N+1.
- Split load accepted in N: reqReady=0 in N+1, respValid=1 in N+2.
- Aligned store accepted in N: memory written at the end of N.
- Split store accepted in N: first word written end of N, second end of N+1; reqReady=0 in N+1.
- Back-to-back: a new request may be accepted in the same cycle respValid is high for the previous one. Throughput is 1/cycle for unsplit accesses.
- A load following a store to the same word in the next cycle returns the new data, because the memory writes at the end of the store cycle.
- Reset values: state IDLE, respValid=0, respData=0, dmemWEnable=0, reqReady=1 (after release).
  - During rst, reqReady=0 and no request is accepted.
  - Reset during SECOND abandons the second half: no write, no response.

## Structure
- Add to BasicTypes:
  - enum MemAccessSize (BYTE, HALF, WORD);
  - typedef ByteEnable (logic [3:0]).
  - Reuse BasicData and MemAddr.
- One sub-module, mem_load_extend: combinational. Inputs are the 64-bit window, off, size and unsigned; output is the 32-bit extended result. It is shared by the split and unsplit paths.

## Test plan
- Byte store 0xAB at addr 0x1001, then word load at 0x1000 (memory preloaded 0x11223344) -> dmemWEnable=0010, dmemWData[15:8]=0xAB; load respValid N+1, respData=0x1122AB44.
- Signed byte load at addr 0x3 of 0x80000000 -> 0xFFFFFF80; same with reqUnsigned=1 -> 0x00000080.
- Half load at addr 0x7, with word1=0xAA000000 and word2=0x000000BB -> reqReady low 1 cycle, respValid at N+2, respData=0xFFFFBBAA.
- Word store 0xDEADBEEF at addr 0x2 -> cycle N mask 1100 on word 0, cycle N+1 mask 0011 on word 1; then word load at 0x2 -> 0xDEADBEEF.
- Word load at the last word, offset 1 (addr 0x1FFFD) -> second read wraps to word 0.
- Assert rst in SECOND of a split store -> second-word write never occurs; respValid stays 0; reqReady=1 after release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types for the load/store access stage: access size encoding,
// byte-enable and data/address word types, FSM state and the load
// metadata carried from request to response.
// Helpers decode the raw 2-bit size field and build the unshifted byte mask.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_access_size_e;

   typedef logic [3:0]  byte_enable_t;
   typedef logic [31:0] basic_data_t;
   typedef logic [31:0] mem_addr_t;

   typedef enum logic {
      ST_IDLE,
      ST_SECOND
   } state_e;

   // Everything the response path needs to shape the returning word.
   typedef struct packed {
      logic [1:0]       off;
      mem_access_size_e size;
      logic             is_unsigned;
      logic             split;
   } load_meta_t;

   // Encoding 3 is illegal and behaves as a word access.
   function automatic mem_access_size_e decode_size(input logic [1:0] raw);
      mem_access_size_e size;
      case (raw)
         2'd0:    size = SIZE_BYTE;
         2'd1:    size = SIZE_HALF;
         default: size = SIZE_WORD;
      endcase
      return size;
   endfunction

   // Byte mask for an access at offset 0, widened to 8 bits so that a
   // later shift by the offset spills into the next word's nibble.
   function automatic logic [7:0] size_mask(input mem_access_size_e size);
      logic [7:0] mask;
      case (size)
         SIZE_BYTE: mask = 8'h01;
         SIZE_HALF: mask = 8'h03;
         default:   mask = 8'h0F;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// ---------------------------------------------------------------------------
// mem_load_extend
// Combinational load result shaper shared by the split and unsplit paths.
// Ports:
//   window      in  64  {upper word, lower word} covering the access
//   off         in  2   byte offset of the access within the lower word
//   size        in      access size
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
// ---------------------------------------------------------------------------
module mem_load_extend
   import mem_access_unit_pkg::*;
(
   input  logic [63:0]      window,
   input  logic [1:0]       off,
   input  mem_access_size_e size,
   input  logic             is_unsigned,
   output basic_data_t      result
);

   logic [63:0] shifted;
   logic        unused_upper;

   assign shifted      = window >> {off, 3'b000};
   assign unused_upper = ^shifted[63:32];

   // NOTE: every branch assigns result, so no latch can be inferred.
   always_comb begin
      result = shifted[31:0];
      case (size)
         SIZE_BYTE: result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default:   result = shifted[31:0];
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store access stage in front of a synchronous-read data memory.
// Accepts one byte-addressed request per cycle, drives the word address,
// byte enables and lane-aligned write data, and returns an extended load
// result the cycle after the (last) read. Accesses crossing a word boundary
// take a second cycle in ST_SECOND, during which the requester is stalled.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqValid/reqReady        request handshake
//   reqIsStore, reqSize,
//   reqUnsigned, reqAddr,
//   reqStoreData             request attributes
//   respValid, respData      load response
//   dmemRAddr                memory read word address
//   dmemWAddr, dmemWEnable,
//   dmemWData                memory write port
//   dmemRData                memory read word (one cycle after dmemRAddr)
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 15
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      reqValid,
   output logic                      reqReady,
   input  logic                      reqIsStore,
   input  logic [1:0]                reqSize,
   input  logic                      reqUnsigned,
   input  mem_addr_t                 reqAddr,
   input  basic_data_t               reqStoreData,
   output logic                      respValid,
   output basic_data_t               respData,
   output logic [MEM_ADDR_WIDTH-1:0] dmemRAddr,
   output logic [MEM_ADDR_WIDTH-1:0] dmemWAddr,
   output byte_enable_t              dmemWEnable,
   output basic_data_t               dmemWData,
   input  basic_data_t               dmemRData
);

   localparam logic [MEM_ADDR_WIDTH-1:0] WORD_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_e                    state, state_next;
   logic                      accept;

   // Request decode
   logic [MEM_ADDR_WIDTH-1:0] word;
   logic [1:0]                off;
   mem_access_size_e          size;
   logic [7:0]                mask8;
   logic [63:0]               store64;
   logic                      split;
   logic                      unused_addr;

   // Second-word transaction, latched on a split accept
   logic [MEM_ADDR_WIDTH-1:0] sec_addr;
   byte_enable_t              sec_mask;
   basic_data_t               sec_data;
   logic                      sec_is_store;

   // Load return path
   load_meta_t                meta;
   logic                      resp_pending;
   basic_data_t               first_word;
   logic [63:0]               window;
   basic_data_t               ext_result;

   assign word        = reqAddr[MEM_ADDR_WIDTH+1:2];
   assign off         = reqAddr[1:0];
   assign size        = decode_size(reqSize);
   assign mask8       = size_mask(size) << off;
   assign store64     = {32'b0, reqStoreData} << {off, 3'b000};
   assign split       = |mask8[7:4];
   // Address bits above the memory are ignored, so accesses wrap.
   assign unused_addr = ^reqAddr[31:MEM_ADDR_WIDTH+2];

   // Held low through reset so nothing is accepted while rst is asserted.
   assign reqReady = (state == ST_IDLE) && !rst;
   assign accept   = reqValid && reqReady;

   always_comb begin
      state_next  = state;
      dmemRAddr   = word;
      dmemWAddr   = word;
      dmemWEnable = '0;
      dmemWData   = store64[31:0];
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (reqIsStore) dmemWEnable = mask8[3:0];
               if (split)      state_next  = ST_SECOND;
            end
         end
         ST_SECOND: begin
            dmemRAddr  = sec_addr;
            dmemWAddr  = sec_addr;
            dmemWData  = sec_data;
            if (sec_is_store) dmemWEnable = sec_mask;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         resp_pending <= 1'b0;
         meta         <= '{off: 2'd0, size: SIZE_BYTE, is_unsigned: 1'b0, split: 1'b0};
         sec_addr     <= '0;
         sec_mask     <= '0;
         sec_data     <= '0;
         sec_is_store <= 1'b0;
         first_word   <= '0;
      end else begin
         state <= state_next;
         // Response fires the cycle after the last read word is addressed.
         resp_pending <= (accept && !reqIsStore && !split) ||
                         (state == ST_SECOND && !sec_is_store);
         if (accept) begin
            meta <= '{off: off, size: size, is_unsigned: reqUnsigned, split: split};
            if (split) begin
               sec_addr     <= word + WORD_ONE;
               sec_mask     <= mask8[7:4];
               sec_data     <= store64[63:32];
               sec_is_store <= reqIsStore;
            end
         end
         // In ST_SECOND the read data is the first word of a split load.
         if (state == ST_SECOND && !sec_is_store) first_word <= dmemRData;
      end
   end

   assign window = meta.split ? {dmemRData, first_word} : {32'b0, dmemRData};

   mem_load_extend u_load_extend (
      .window      (window),
      .off         (meta.off),
      .size        (meta.size),
      .is_unsigned (meta.is_unsigned),
      .result      (ext_result)
   );

   assign respValid = resp_pending;
   assign respData  = resp_pending ? ext_result : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a behavioural synchronous-read,
// byte-writable data memory. Inputs change and outputs are sampled just after
// the falling edge; the design's rising edge lies between steps.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int AW = 15;

   logic          clk;
   logic          rst;
   logic          reqValid;
   logic          reqReady;
   logic          reqIsStore;
   logic [1:0]    reqSize;
   logic          reqUnsigned;
   logic [31:0]   reqAddr;
   logic [31:0]   reqStoreData;
   logic          respValid;
   logic [31:0]   respData;
   logic [AW-1:0] dmemRAddr;
   logic [AW-1:0] dmemWAddr;
   logic [3:0]    dmemWEnable;
   logic [31:0]   dmemWData;
   logic [31:0]   dmemRData;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [31:0]   pl_data;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(.MEM_ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .reqValid     (reqValid),
      .reqReady     (reqReady),
      .reqIsStore   (reqIsStore),
      .reqSize      (reqSize),
      .reqUnsigned  (reqUnsigned),
      .reqAddr      (reqAddr),
      .reqStoreData (reqStoreData),
      .respValid    (respValid),
      .respData     (respData),
      .dmemRAddr    (dmemRAddr),
      .dmemWAddr    (dmemWAddr),
      .dmemWEnable  (dmemWEnable),
      .dmemWData    (dmemWData),
      .dmemRData    (dmemRData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: byte-enabled write and registered read on the same edge,
   // so a read issued the cycle after a write sees the new data.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      for (int i = 0; i < 4; i++)
         if (dmemWEnable[i]) mem[dmemWAddr][8*i +: 8] <= dmemWData[8*i +: 8];
      dmemRData <= mem[dmemRAddr];
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic req(input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] sdata);
      reqValid     = 1'b1;
      reqIsStore   = st;
      reqSize      = sz;
      reqUnsigned  = uns;
      reqAddr      = addr;
      reqStoreData = sdata;
   endtask

   task automatic idle();
      reqValid     = 1'b0;
      reqIsStore   = 1'b0;
      reqSize      = 2'd0;
      reqUnsigned  = 1'b0;
      reqAddr      = 32'h0;
      reqStoreData = 32'h0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      pl_en   = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      idle();

      // Reset state
      repeat (2) @(negedge clk);
      reqValid = 1'b1;
      #1;
      check("rst_ready_low", {31'b0, reqReady}, 32'd0);
      check("rst_resp_valid", {31'b0, respValid}, 32'd0);
      check("rst_wen", {28'b0, dmemWEnable}, 32'd0);
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      check("post_rst_ready", {31'b0, reqReady}, 32'd1);
      check("post_rst_resp_data", respData, 32'h0);

      // Byte store into a preloaded word, then read it back
      preload(15'h400, 32'h11223344);
      @(negedge clk);
      req(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h0000_00AB);
      #1;
      check("bst_wen", {28'b0, dmemWEnable}, 32'h2);
      check("bst_wdata", dmemWData, 32'h0000_AB00);
      check("bst_waddr", {17'b0, dmemWAddr}, 32'h400);
      @(negedge clk);
      req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
      #1;
      check("ld_after_st_no_resp", {31'b0, respValid}, 32'd0);
      check("ld_wen_zero", {28'b0, dmemWEnable}, 32'd0);
      check("ld_raddr", {17'b0, dmemRAddr}, 32'h400);
      @(negedge clk);
      req(1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0);  // size 3 acts as word
      #1;
      check("ld_word_valid", {31'b0, respValid}, 32'd1);
      check("ld_word_data", respData, 32'h1122_AB44);
      @(negedge clk);
      idle();
      #1;
      check("ld_size3_valid", {31'b0, respValid}, 32'd1);
      check("ld_size3_data", respData, 32'h1122_AB44);

      // Signed then unsigned byte load, back to back
      preload(15'h0, 32'h8000_0000);
      @(negedge clk);
      req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
      @(negedge clk);
      req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
      #1;
      check("lb_signed_valid", {31'b0, respValid}, 32'd1);
      check("lb_signed_data", respData, 32'hFFFF_FF80);
      check("lb_b2b_ready", {31'b0, reqReady}, 32'd1);
      @(negedge clk);
      idle();
      #1;
      check("lbu_data", respData, 32'h0000_0080);
      @(negedge clk);
      #1;
      check("lbu_single_resp", {31'b0, respValid}, 32'd0);

      // Split half load across words 1 and 2
      preload(15'h1, 32'hAA00_0000);
      preload(15'h2, 32'h0000_00BB);
      @(negedge clk);
      req(1'b0, 2'd1, 1'b0, 32'h7, 32'h0);
      #1;
      check("lh_split_raddr0", {17'b0, dmemRAddr}, 32'h1);
      @(negedge clk);
      idle();
      #1;
      check("lh_split_stall", {31'b0, reqReady}, 32'd0);
      check("lh_split_raddr1", {17'b0, dmemRAddr}, 32'h2);
      check("lh_split_no_early_resp", {31'b0, respValid}, 32'd0);
      @(negedge clk);
      #1;
      check("lh_split_valid", {31'b0, respValid}, 32'd1);
      check("lh_split_data", respData, 32'hFFFF_BBAA);
      check("lh_split_ready_back", {31'b0, reqReady}, 32'd1);

      // Split word store at offset 2, then reload it
      @(negedge clk);
      req(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_BEEF);
      #1;
      check("sw_split_wen0", {28'b0, dmemWEnable}, 32'hC);
      check("sw_split_waddr0", {17'b0, dmemWAddr}, 32'h0);
      check("sw_split_wdata0", dmemWData, 32'hBEEF_0000);
      @(negedge clk);
      idle();
      #1;
      check("sw_split_stall", {31'b0, reqReady}, 32'd0);
      check("sw_split_wen1", {28'b0, dmemWEnable}, 32'h3);
      check("sw_split_waddr1", {17'b0, dmemWAddr}, 32'h1);
      check("sw_split_wdata1", dmemWData, 32'h0000_DEAD);
      check("sw_no_resp", {31'b0, respValid}, 32'd0);
      @(negedge clk);
      req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
      #1;
      check("sw_mem0", mem[0], 32'hBEEF_0000);
      check("sw_mem1", mem[1], 32'hAA00_DEAD);
      @(negedge clk);
      idle();
      #1;
      check("lw_split_stall", {31'b0, reqReady}, 32'd0);
      @(negedge clk);
      #1;
      check("lw_split_valid", {31'b0, respValid}, 32'd1);
      check("lw_split_data", respData, 32'hDEAD_BEEF);

      // Split load at the last word wraps to word 0
      preload(15'h7FFF, 32'h4433_2211);
      preload(15'h0, 32'h8877_6655);
      @(negedge clk);
      req(1'b0, 2'd2, 1'b0, 32'h0001_FFFD, 32'h0);
      #1;
      check("wrap_raddr0", {17'b0, dmemRAddr}, 32'h7FFF);
      @(negedge clk);
      idle();
      #1;
      check("wrap_raddr1", {17'b0, dmemRAddr}, 32'h0);
      @(negedge clk);
      #1;
      check("wrap_valid", {31'b0, respValid}, 32'd1);
      check("wrap_data", respData, 32'h5544_3322);

      // Reset while the second half of a split store is pending
      preload(15'h5, 32'h1234_5678);
      preload(15'h6, 32'h1234_5678);
      @(negedge clk);
      req(1'b1, 2'd2, 1'b0, 32'h15, 32'hCAFE_F00D);
      #1;
      check("rst2_wen0", {28'b0, dmemWEnable}, 32'hE);
      check("rst2_waddr0", {17'b0, dmemWAddr}, 32'h5);
      @(negedge clk);
      idle();
      #1;
      check("rst2_in_second", {31'b0, reqReady}, 32'd0);
      rst = 1'b1;
      #1;
      check("rst2_wen_killed", {28'b0, dmemWEnable}, 32'd0);
      check("rst2_ready_low", {31'b0, reqReady}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst2_ready_back", {31'b0, reqReady}, 32'd1);
      check("rst2_no_resp", {31'b0, respValid}, 32'd0);
      check("rst2_mem5", mem[5], 32'hFEF0_0D78);
      @(negedge clk);
      #1;
      check("rst2_mem6_untouched", mem[6], 32'h1234_5678);
      check("rst2_still_no_resp", {31'b0, respValid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
